stepper_motor_multi: RTL
========================

// Module: stepper_motor_multi
// PURPOSE
//   Multi-channel stepper pulse generator, successor to the single-channel stepper_motor.
//   Each channel independently emits N step pulses at a programmed rate and direction.
//   Direction is changed with an enforced setup time before the first step.
//   Sits behind the GPMC register file; config/command fields map to mem[] words in top.
// PARAMETERS
//   CHANNELS   2   number of independent motor channels
//   CNT_WIDTH  16  width of step count / remaining counter
//   DIV_WIDTH  16  width of half-period divider (clk cycles per step_out level)
//   DIR_SETUP  4   clk cycles dir_out is held stable before first step_out rise (>=1)
// PORTS
//   clk          in   1                   system clock
//   reset_n      in   1                   async active-low reset
//   start        in   CHANNELS            per-channel start pulse (1 cycle)
//   stop         in   CHANNELS            per-channel abort (level or pulse)
//   dir          in   CHANNELS            requested direction, sampled at start
//   steps        in   CHANNELS*CNT_WIDTH  step count, ch k at [k*CNT_WIDTH +: CNT_WIDTH]
//   half_period  in   CHANNELS*DIV_WIDTH  step_out high/low time in clk cycles, same packing
//   step_out     out  CHANNELS            step pulse to driver
//   dir_out      out  CHANNELS            direction to driver
//   busy         out  CHANNELS            channel not in IDLE
//   done         out  CHANNELS            1-cycle pulse on normal completion
//   remaining    out  CHANNELS*CNT_WIDTH  steps still to issue
// BEHAVIOUR
//   - Reset (async, reset_n=0): all channels IDLE; step_out=0, dir_out=0, busy=0, done=0,
//     remaining=0, divider=0. Release synchronous to clk.
//   - Per-channel FSM IDLE -> SETUP -> STEP_HI <-> STEP_LO -> DONE -> IDLE; channels share nothing.
//   - IDLE: start=1 & stop=0 latches dir->dir_out, steps->remaining, half_period->hp_lat
//     (hp=0 latched as 1); next state SETUP. start & steps=0: go DONE directly, no pulses.
//   - SETUP: DIR_SETUP cycles, step_out=0. First step_out rise DIR_SETUP+1 cycles after start edge.
//   - STEP_HI: step_out=1 for hp_lat cycles -> STEP_LO.
//   - STEP_LO: step_out=0 for hp_lat cycles; on exit remaining-=1; remaining now 0 -> DONE,
//     else STEP_HI. Step period = 2*hp_lat cycles exactly, no gap cycles.
//   - DONE: done=1 for one cycle, busy=0 same cycle, -> IDLE. dir_out holds last value.
//   - busy=1 in SETUP/STEP_HI/STEP_LO only.
//   - start while busy: ignored; latched values unchanged. steps/half_period/dir changes
//     while busy have no effect.
//   - stop in any non-IDLE state: next cycle IDLE, step_out=0, no done pulse; remaining keeps
//     the unissued count (a step in STEP_HI is not counted). start & stop same cycle: stop wins.
//   - remaining never underflows; max steps 2^CNT_WIDTH-1, max hp 2^DIV_WIDTH-1.
// CONFIGURATION
//   STEPPER_POSITION_EN defined: adds output position [CHANNELS*(CNT_WIDTH+8)] signed
//     per channel, reset 0; +1 per completed step with dir_out=1, -1 with dir_out=0
//     (at STEP_LO exit, incl. steps before an abort); wraps two's-complement.
//   Undefined: port and counters absent; all other behaviour identical.
// TESTING
//   1. Reset: reset_n=0 mid-STEP_HI -> step_out=0, busy=0, remaining=0 immediately (async).
//   2. ch0 dir=1 steps=3 hp=2 start -> dir_out=1 at +1, step_out rises at +5, 3 pulses
//      high 2/low 2, done pulse at +17, remaining 3->0.
//   3. ch0 steps=0 start -> no step_out, done pulse 2 cycles after start, busy stays 0.
//   4. ch0 steps=10 hp=1, stop after 4th rising step_out -> step_out 0 next cycle,
//      no done, remaining=7; start+stop same cycle in IDLE -> no action.
//   5. ch0 and ch1 started same cycle, hp=3 and hp=5 -> independent periods 6 and 10;
//      start re-issued on ch0 while busy ignored (pulse count unchanged).
//   6. STEPPER_POSITION_EN: 5 steps dir=1 then 7 steps dir=0 -> position=-2; hp=0 runs as hp=1.

Source files
------------

// File: rtl/stepper_motor_multi_if.sv
// rtl/stepper_motor_multi_if.sv - command/status bundle for stepper_motor_multi (position port under STEPPER_POSITION_EN)
`timescale 1ns/1ps
interface stepper_motor_multi_if #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 16
);
    logic [CHANNELS-1:0]           start;
    logic [CHANNELS-1:0]           stop;
    logic [CHANNELS-1:0]           dir;
    logic [CHANNELS*CNT_WIDTH-1:0] steps;
    logic [CHANNELS*DIV_WIDTH-1:0] half_period;
    logic [CHANNELS-1:0]           step_out;
    logic [CHANNELS-1:0]           dir_out;
    logic [CHANNELS-1:0]           busy;
    logic [CHANNELS-1:0]           done;
    logic [CHANNELS*CNT_WIDTH-1:0] remaining;
`ifdef STEPPER_POSITION_EN
    logic [CHANNELS*(CNT_WIDTH+8)-1:0] position;
`endif

    modport master (
        output start, stop, dir, steps, half_period,
        input  step_out, dir_out, busy, done, remaining
`ifdef STEPPER_POSITION_EN
        , input position
`endif
    );

    modport slave (
        input  start, stop, dir, steps, half_period,
        output step_out, dir_out, busy, done, remaining
`ifdef STEPPER_POSITION_EN
        , output position
`endif
    );
endinterface

// File: rtl/stepper_motor_multi.sv
// rtl/stepper_motor_multi.sv - multi-channel stepper pulse generator; STEPPER_POSITION_EN adds signed position counters
`timescale 1ns/1ps
module stepper_motor_multi #(
    parameter int CHANNELS  = 2,
    parameter int CNT_WIDTH = 16,
    parameter int DIV_WIDTH = 16,
    parameter int DIR_SETUP = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stepper_motor_multi_if.slave  bus
);
    // S_NULL is the one-cycle hop a zero-step command takes before its done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STEP_HI, S_STEP_LO, S_NULL, S_DONE
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] SETUP_LAST = DIV_WIDTH'(DIR_SETUP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [CHANNELS-1:0]           step_out_v, dir_out_v, busy_v, done_v;
    logic [CHANNELS*CNT_WIDTH-1:0] remaining_v;
`ifdef STEPPER_POSITION_EN
    localparam logic signed [CNT_WIDTH+7:0] POS_ONE = (CNT_WIDTH+8)'(1);
    logic [CHANNELS*(CNT_WIDTH+8)-1:0] position_v;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        state_t                state_q, state_d;
        logic                  dir_q, dir_d;
        logic [CNT_WIDTH-1:0]  rem_q, rem_d;
        logic [DIV_WIDTH-1:0]  hp_q, hp_d;
        logic [DIV_WIDTH-1:0]  div_q, div_d;
        logic [CNT_WIDTH-1:0]  steps_in;
        logic [DIV_WIDTH-1:0]  hp_in;
`ifdef STEPPER_POSITION_EN
        logic signed [CNT_WIDTH+7:0] pos_q, pos_d;
`endif

        assign steps_in = bus.steps[k*CNT_WIDTH +: CNT_WIDTH];
        assign hp_in    = bus.half_period[k*DIV_WIDTH +: DIV_WIDTH];

        always_comb begin
            state_d = state_q;
            dir_d   = dir_q;
            rem_d   = rem_q;
            hp_d    = hp_q;
            div_d   = div_q + DIV_ONE;
`ifdef STEPPER_POSITION_EN
            pos_d   = pos_q;
`endif
            // Abort beats everything, including a same-cycle step completion
            if (state_q != S_IDLE && bus.stop[k]) begin
                state_d = S_IDLE;
                div_d   = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        div_d = '0;
                        if (bus.start[k] && !bus.stop[k]) begin
                            dir_d   = bus.dir[k];
                            rem_d   = steps_in;
                            hp_d    = (hp_in == '0) ? DIV_ONE : hp_in;
                            state_d = (steps_in == '0) ? S_NULL : S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (div_q == SETUP_LAST) begin
                            div_d   = '0;
                            state_d = S_STEP_HI;
                        end
                    end
                    S_STEP_HI: begin
                        if (div_q == hp_q - DIV_ONE) begin
                            div_d   = '0;
                            state_d = S_STEP_LO;
                        end
                    end
                    S_STEP_LO: begin
                        if (div_q == hp_q - DIV_ONE) begin
                            div_d   = '0;
                            rem_d   = rem_q - CNT_ONE;
                            state_d = (rem_q == CNT_ONE) ? S_DONE : S_STEP_HI;
`ifdef STEPPER_POSITION_EN
                            pos_d   = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
`endif
                        end
                    end
                    S_NULL: begin
                        div_d   = '0;
                        state_d = S_DONE;
                    end
                    S_DONE: begin
                        div_d   = '0;
                        state_d = S_IDLE;
                    end
                    default: begin
                        div_d   = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= S_IDLE;
                dir_q   <= 1'b0;
                rem_q   <= '0;
                hp_q    <= '0;
                div_q   <= '0;
`ifdef STEPPER_POSITION_EN
                pos_q   <= '0;
`endif
            end else begin
                state_q <= state_d;
                dir_q   <= dir_d;
                rem_q   <= rem_d;
                hp_q    <= hp_d;
                div_q   <= div_d;
`ifdef STEPPER_POSITION_EN
                pos_q   <= pos_d;
`endif
            end
        end

        assign step_out_v[k] = (state_q == S_STEP_HI);
        assign dir_out_v[k]  = dir_q;
        assign busy_v[k]     = (state_q == S_SETUP) || (state_q == S_STEP_HI) ||
                               (state_q == S_STEP_LO);
        assign done_v[k]     = (state_q == S_DONE);
        assign remaining_v[k*CNT_WIDTH +: CNT_WIDTH] = rem_q;
`ifdef STEPPER_POSITION_EN
        assign position_v[k*(CNT_WIDTH+8) +: (CNT_WIDTH+8)] = pos_q;
`endif
    end

    assign bus.step_out  = step_out_v;
    assign bus.dir_out   = dir_out_v;
    assign bus.busy      = busy_v;
    assign bus.done      = done_v;
    assign bus.remaining = remaining_v;
`ifdef STEPPER_POSITION_EN
    assign bus.position  = position_v;
`endif
endmodule
